core_control_fsm: RTL and testbench

- Main sequencing FSM for the multicycle RV32I core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK over a single shared instruction/data memory port.
- Generates all register write-enables, memory handshakes and trap strobes; the combinational decoder supplies the mux selects.
- Also detects illegal instructions, ECALL/EBREAK, MRET, interrupts and memory timeouts, and routes them through a TRAP state.

---
 rtl/core_control_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_core_control_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_control_fsm.sv
// Purpose: multicycle RV32I sequencer (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP) over one shared memory port.
// Latency: with 1-cycle memory, branch 3, ALU/JAL/CSR/store 4, load 5 cycles per instruction.
// Backpressure: FETCH/MEM hold mem_req until mem_ack; a bounded wait (MEM_TIMEOUT) turns into an access-fault trap.
module core_control_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [11:0] funct12,
  input  logic        trap_pending,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        alu_out_we,
  output logic        reg_we,
  output logic        csr_we,
  output logic        pc_we,
  output logic        trap_take,
  output logic        trap_finish,
  output logic [3:0]  trap_cause,
  output logic        retire,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;
  localparam logic [11:0] F12_WFI    = 12'h105;

  localparam logic [3:0] CAUSE_IFETCH  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_LDFAULT = 4'd5;
  localparam logic [3:0] CAUSE_STFAULT = 4'd7;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  // Interrupts share code 11; the CSR unit tells them apart by its own pending flag.
  localparam logic [3:0] CAUSE_IRQ     = 4'hB;

  // Counter only needs to hold MEM_TIMEOUT-1, the last waiting cycle before giving up.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cause_q, cause_d;

  logic is_store;
  logic is_priv;
  logic timeout;
  logic legal;

  assign is_store = (opcode == OPC_STORE);
  assign is_priv  = (opcode == OPC_SYSTEM) && (func3 == 3'b000);
  assign timeout  = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign state    = state_q;

  // Opcode legality check used in DECODE.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: legal = 1'b1;
      OPC_SYSTEM: legal = (func3 != 3'b000) ||
                          (funct12 == F12_ECALL) || (funct12 == F12_EBREAK) ||
                          (funct12 == F12_MRET)  || (funct12 == F12_WFI);
      default: legal = 1'b0;
    endcase
  end

  // State, wait counter and latched trap cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic; the wait counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IFETCH;
        end
      end
      S_DECODE: begin
        if (trap_pending) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IRQ;
        end else if (!legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE:        state_d = S_MEM;
          OPC_BRANCH, OPC_MISC_MEM:   state_d = S_FETCH;
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
          OPC_OP, OPC_OP_IMM:         state_d = S_WRITEBACK;
          OPC_SYSTEM: begin
            if (func3 != 3'b000) begin
              state_d = S_WRITEBACK;
            end else if (funct12 == F12_MRET || funct12 == F12_WFI) begin
              state_d = S_FETCH;
            end else if (funct12 == F12_ECALL) begin
              state_d = S_TRAP;
              cause_d = CAUSE_ECALL;
            end else if (funct12 == F12_EBREAK) begin
              state_d = S_TRAP;
              cause_d = CAUSE_BREAK;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = is_store ? S_FETCH : S_WRITEBACK;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = is_store ? CAUSE_STFAULT : CAUSE_LDFAULT;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase

    cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;

    if (rst) begin
      state_d = S_FETCH;
      cnt_d   = '0;
    end
  end

  // Output strobes decoded from the current state; everything is held low during reset.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 1'b0;
    ir_we       = 1'b0;
    alu_out_we  = 1'b0;
    reg_we      = 1'b0;
    csr_we      = 1'b0;
    pc_we       = 1'b0;
    trap_take   = 1'b0;
    trap_finish = 1'b0;
    trap_cause  = 4'd0;
    retire      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
        end
        S_EXECUTE: begin
          alu_out_we = 1'b1;
          if (opcode == OPC_BRANCH || opcode == OPC_MISC_MEM ||
              (is_priv && (funct12 == F12_MRET || funct12 == F12_WFI))) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
          trap_finish = is_priv && (funct12 == F12_MRET);
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = is_store;
          if (mem_ack && is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WRITEBACK: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          csr_we = (opcode == OPC_SYSTEM);
        end
        S_TRAP: begin
          trap_take  = 1'b1;
          pc_we      = 1'b1;
          trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_control_fsm.sv
// Directed bench for core_control_fsm built with a 4-cycle memory timeout.
// Inputs change 1 ns after each rising edge; outputs are compared 2 ns after it.
// Strobes are compared as one packed vector per cycle alongside state and trap_cause.
module tb_core_control_fsm;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [11:0] funct12;
  logic        trap_pending;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_sel, ir_we, alu_out_we, reg_we, csr_we;
  logic        pc_we, trap_take, trap_finish, retire;
  logic [3:0]  trap_cause;
  logic [2:0]  state;

  int checks;
  int passed;

  // Strobe vector bit weights
  localparam logic [10:0] REQ = 11'h400;
  localparam logic [10:0] WE  = 11'h200;
  localparam logic [10:0] SEL = 11'h100;
  localparam logic [10:0] IR  = 11'h080;
  localparam logic [10:0] ALU = 11'h040;
  localparam logic [10:0] RWE = 11'h020;
  localparam logic [10:0] CSR = 11'h010;
  localparam logic [10:0] PC  = 11'h008;
  localparam logic [10:0] TT  = 11'h004;
  localparam logic [10:0] TF  = 11'h002;
  localparam logic [10:0] RET = 11'h001;
  localparam logic [10:0] NONE = 11'h000;

  logic [10:0] strb;
  assign strb = {mem_req, mem_we, mem_sel, ir_we, alu_out_we, reg_we,
                 csr_we, pc_we, trap_take, trap_finish, retire};

  core_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .func3        (func3),
    .funct12      (funct12),
    .trap_pending (trap_pending),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .ir_we        (ir_we),
    .alu_out_we   (alu_out_we),
    .reg_we       (reg_we),
    .csr_we       (csr_we),
    .pc_we        (pc_we),
    .trap_take    (trap_take),
    .trap_finish  (trap_finish),
    .trap_cause   (trap_cause),
    .retire       (retire),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Let the combinational outputs settle, then compare state, strobes and cause.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] s, input logic [3:0] cause);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".strobes"}, 32'(strb), 32'(s));
    chk({tag, ".cause"}, 32'(trap_cause), 32'(cause));
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    opcode = 7'b0110011;
    func3 = 3'd0;
    funct12 = 12'h000;
    trap_pending = 1'b1;
    mem_ack = 1'b1;

    // Reset: outputs forced low even with ack/pending asserted
    tick(); tick();
    cyc("reset", 3'd0, NONE, 4'd0);

    // First fetch request right after reset release
    tick(); rst = 1'b0; mem_ack = 1'b0; trap_pending = 1'b0;
    cyc("fetch_first", 3'd0, REQ, 4'd0);

    // ADD: 4 cycles with 1-cycle ack
    tick(); mem_ack = 1'b1;
    cyc("add_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("add_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("add_exec", 3'd2, ALU, 4'd0);
    tick(); cyc("add_wb", 3'd4, RWE | PC | RET, 4'd0);

    // LOAD with data ack on the 4th MEM cycle
    tick(); opcode = 7'b0000011; mem_ack = 1'b1;
    cyc("ld_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("ld_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("ld_exec", 3'd2, ALU, 4'd0);
    tick(); cyc("ld_mem0", 3'd3, REQ | SEL, 4'd0);
    tick(); cyc("ld_mem1", 3'd3, REQ | SEL, 4'd0);
    tick(); cyc("ld_mem2", 3'd3, REQ | SEL, 4'd0);
    tick(); mem_ack = 1'b1;
    cyc("ld_mem3_ack", 3'd3, REQ | SEL, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("ld_wb", 3'd4, RWE | PC | RET, 4'd0);

    // STORE with data ack on the 4th MEM cycle; retires on the ack cycle
    tick(); opcode = 7'b0100011; mem_ack = 1'b1;
    cyc("st_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("st_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("st_exec", 3'd2, ALU, 4'd0);
    tick(); cyc("st_mem0", 3'd3, REQ | WE | SEL, 4'd0);
    tick(); cyc("st_mem1", 3'd3, REQ | WE | SEL, 4'd0);
    tick(); cyc("st_mem2", 3'd3, REQ | WE | SEL, 4'd0);
    tick(); mem_ack = 1'b1;
    cyc("st_mem3_ack", 3'd3, REQ | WE | SEL | PC | RET, 4'd0);

    // Illegal opcode 1111111 -> trap cause 2
    tick(); opcode = 7'b1111111; mem_ack = 1'b1;
    cyc("ill_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("ill_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("ill_trap", 3'd5, TT | PC, 4'd2);

    // ECALL -> cause 11
    tick(); opcode = 7'b1110011; func3 = 3'd0; funct12 = 12'h000; mem_ack = 1'b1;
    cyc("ecall_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("ecall_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("ecall_exec", 3'd2, ALU, 4'd0);
    tick(); cyc("ecall_trap", 3'd5, TT | PC, 4'd11);

    // EBREAK -> cause 3
    tick(); funct12 = 12'h001; mem_ack = 1'b1;
    cyc("ebreak_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("ebreak_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("ebreak_exec", 3'd2, ALU, 4'd0);
    tick(); cyc("ebreak_trap", 3'd5, TT | PC, 4'd3);

    // MRET -> trap_finish + retire in EXECUTE, no trap_take
    tick(); funct12 = 12'h302; mem_ack = 1'b1;
    cyc("mret_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("mret_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("mret_exec", 3'd2, ALU | PC | TF | RET, 4'd0);

    // BRANCH: 3 cycles
    tick(); opcode = 7'b1100011; mem_ack = 1'b1;
    cyc("br_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("br_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("br_exec", 3'd2, ALU | PC | RET, 4'd0);

    // CSRRW: writeback with csr_we
    tick(); opcode = 7'b1110011; func3 = 3'd1; funct12 = 12'h340; mem_ack = 1'b1;
    cyc("csr_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("csr_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("csr_exec", 3'd2, ALU, 4'd0);
    tick(); cyc("csr_wb", 3'd4, RWE | CSR | PC | RET, 4'd0);

    // Fetch never acked: 4 request cycles, then TRAP cause 1; late ack ignored
    tick(); func3 = 3'd0; funct12 = 12'h000;
    cyc("fto_w0", 3'd0, REQ, 4'd0);
    tick(); cyc("fto_w1", 3'd0, REQ, 4'd0);
    tick(); cyc("fto_w2", 3'd0, REQ, 4'd0);
    tick(); cyc("fto_w3", 3'd0, REQ, 4'd0);
    tick(); mem_ack = 1'b1;
    cyc("fto_trap", 3'd5, TT | PC, 4'd1);

    // LOAD data timeout -> cause 5
    tick(); opcode = 7'b0000011; mem_ack = 1'b1;
    cyc("ldto_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("ldto_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("ldto_exec", 3'd2, ALU, 4'd0);
    tick(); cyc("ldto_w0", 3'd3, REQ | SEL, 4'd0);
    tick(); cyc("ldto_w1", 3'd3, REQ | SEL, 4'd0);
    tick(); cyc("ldto_w2", 3'd3, REQ | SEL, 4'd0);
    tick(); cyc("ldto_w3", 3'd3, REQ | SEL, 4'd0);
    tick(); cyc("ldto_trap", 3'd5, TT | PC, 4'd5);

    // Interrupt pending with illegal opcode in DECODE: single interrupt trap
    tick(); opcode = 7'b1111111; mem_ack = 1'b1;
    cyc("irq_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0; trap_pending = 1'b1;
    cyc("irq_decode", 3'd1, NONE, 4'd0);
    tick(); trap_pending = 1'b0;
    cyc("irq_trap", 3'd5, TT | PC, 4'd11);

    // Reset pulse while a store waits in MEM
    tick(); opcode = 7'b0100011; mem_ack = 1'b1;
    cyc("rmem_fetch", 3'd0, REQ | IR, 4'd0);
    tick(); mem_ack = 1'b0;
    cyc("rmem_decode", 3'd1, NONE, 4'd0);
    tick(); cyc("rmem_exec", 3'd2, ALU, 4'd0);
    tick(); cyc("rmem_mem", 3'd3, REQ | WE | SEL, 4'd0);
    tick(); rst = 1'b1; mem_ack = 1'b1;
    cyc("rmem_rst", 3'd3, NONE, 4'd0);
    tick(); rst = 1'b0; mem_ack = 1'b0;
    cyc("rmem_refetch", 3'd0, REQ, 4'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
